// File: rtl/fft_in_loader_if.sv
// Coefficient stream in, FFT input port out: the loader's bus bundle.
// Latency: none, wires only.
// Backpressure: coef_valid/coef_ready upstream; the FFT side has no ready signal.
// INT2FP_EN narrows coef_data to a 16-bit two's-complement integer.
interface fft_in_loader_if #(
    parameter int FLOAT_PRECISION = 64
);
`ifdef INT2FP_EN
    localparam int COEF_W = 16;
`else
    localparam int COEF_W = FLOAT_PRECISION;
`endif

    logic                       coef_valid;
    logic [COEF_W-1:0]          coef_data;
    logic                       coef_ready;
    logic                       abort;
    logic                       in_valid;
    logic [FLOAT_PRECISION-1:0] fi_re;
    logic [FLOAT_PRECISION-1:0] fi_im;
    logic                       frame_done;

    // upstream producer / frame controller view
    modport master (
        output coef_valid, coef_data, abort,
        input  coef_ready, in_valid, fi_re, fi_im, frame_done
    );

    // loader view
    modport slave (
        input  coef_valid, coef_data, abort,
        output coef_ready, in_valid, fi_re, fi_im, frame_done
    );
endinterface

// File: rtl/fft_in_loader.sv
// Buffers one N-coefficient real frame, then emits HN contiguous complex pairs (f[k], f[k+HN]).
// Latency: first in_valid beat 1 cycle after the last accepted coefficient; all outputs registered.
// Backpressure: coef_ready low for the whole burst; FFT side cannot stall. INT2FP_EN: int16 input.
module fft_in_loader #(
    parameter int FLOAT_PRECISION = 64,
    parameter int logn            = 8    // must be >= 1
) (
    input  logic            clk,
    input  logic            rst,
    fft_in_loader_if.slave  bus
);
    localparam int N = 1 << (logn + 1);

    localparam logic [0:0] S_LOAD = 1'b0;
    localparam logic [0:0] S_EMIT = 1'b1;

    localparam logic [logn:0] CNT_ONE  = {{logn{1'b0}}, 1'b1};
    localparam logic [logn:0] WR_LAST  = {(logn + 1){1'b1}};          // N-1
    localparam logic [logn:0] HN_IDX   = {1'b1, {logn{1'b0}}};        // HN
    localparam logic [logn:0] RD_LAST  = {1'b0, {logn{1'b1}}};        // HN-1

    logic [0:0]                 state;
    logic [logn:0]              wr_cnt;
    logic [logn:0]              rd_cnt;
    logic                       coef_ready_q;
    logic                       in_valid_q;
    logic                       frame_done_q;
    logic [FLOAT_PRECISION-1:0] fi_re_q;
    logic [FLOAT_PRECISION-1:0] fi_im_q;
    logic [FLOAT_PRECISION-1:0] mem [N];
    logic [FLOAT_PRECISION-1:0] wdat;
    logic [logn-1:0]            rd_lo;
    logic                       accept;

`ifdef INT2FP_EN
    // Exact int16 -> IEEE-754 double; zero maps to +0.
    function automatic logic [63:0] int2fp(input logic [15:0] x);
        logic [15:0] mag;
        logic [3:0]  p;
        logic [52:0] sh;
        logic [10:0] e;
        mag = x[15] ? (~x + 16'd1) : x;
        p   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (mag[i]) p = 4'(i);
        end
        sh = {37'd0, mag} << (6'd52 - {2'b00, p});
        e  = 11'd1023 + {7'd0, p};
        if (mag == 16'd0) int2fp = 64'd0;
        else              int2fp = {x[15], e, sh[51:0]};
    endfunction

    assign wdat = FLOAT_PRECISION'(int2fp(bus.coef_data));
`else
    assign wdat = bus.coef_data;
`endif

    // coef_ready is only ever high in LOAD; abort drops the coefficient of its cycle
    assign accept = (state == S_LOAD) && bus.coef_valid && coef_ready_q && !bus.abort;
    assign rd_lo  = rd_cnt[logn-1:0];

    assign bus.coef_ready = coef_ready_q;
    assign bus.in_valid   = in_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.fi_re      = fi_re_q;
    assign bus.fi_im      = fi_im_q;

    // Frame buffer write port; contents deliberately left unreset
    always_ff @(posedge clk) begin
        if (accept) mem[wr_cnt] <= wdat;
    end

    // Load/emit sequencing with abort taking priority over everything else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_LOAD;
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            coef_ready_q <= 1'b0;
            in_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            fi_re_q      <= '0;
            fi_im_q      <= '0;
        end else if (bus.abort) begin
            state        <= S_LOAD;
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            coef_ready_q <= 1'b1;
            in_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            fi_re_q      <= '0;
            fi_im_q      <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    coef_ready_q <= 1'b1;
                    in_valid_q   <= 1'b0;
                    frame_done_q <= 1'b0;
                    fi_re_q      <= '0;
                    fi_im_q      <= '0;
                    if (accept) begin
                        if (wr_cnt == WR_LAST) begin
                            // last coefficient: beat 0 goes out on this very edge
                            wr_cnt       <= '0;
                            state        <= S_EMIT;
                            coef_ready_q <= 1'b0;
                            in_valid_q   <= 1'b1;
                            fi_re_q      <= mem[0];
                            fi_im_q      <= mem[HN_IDX];
                            rd_cnt       <= CNT_ONE;
                        end else begin
                            wr_cnt <= wr_cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    coef_ready_q <= 1'b0;
                    if (rd_cnt == HN_IDX) begin
                        // beat HN-1 has been presented; return to loading
                        state        <= S_LOAD;
                        rd_cnt       <= '0;
                        coef_ready_q <= 1'b1;
                        in_valid_q   <= 1'b0;
                        frame_done_q <= 1'b0;
                        fi_re_q      <= '0;
                        fi_im_q      <= '0;
                    end else begin
                        in_valid_q   <= 1'b1;
                        fi_re_q      <= mem[{1'b0, rd_lo}];
                        fi_im_q      <= mem[{1'b1, rd_lo}];
                        frame_done_q <= (rd_cnt == RD_LAST);
                        rd_cnt       <= rd_cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fft_in_loader.sv
// Directed bench for fft_in_loader at logn=2 (N=8, HN=4).
// Inputs driven and outputs sampled on the falling clock edge.
// Build with INT2FP_EN defined to exercise the integer input path as well.
module tb_fft_in_loader;
    localparam int FP   = 64;
    localparam int LOGN = 2;
`ifdef INT2FP_EN
    localparam int CW = 16;
`else
    localparam int CW = 64;
`endif

    typedef int frame_t [8];

    logic clk = 1'b0;
    logic rst;
    int   n_err = 0;
    int   n_chk = 0;

    fft_in_loader_if #(.FLOAT_PRECISION(FP)) bus();

    fft_in_loader #(.FLOAT_PRECISION(FP), .logn(LOGN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] enc(input int v);
`ifdef INT2FP_EN
        enc = v[CW-1:0];
`else
        enc = $realtobits(real'(v));
`endif
    endfunction

    function automatic logic [63:0] dbl(input int v);
        dbl = $realtobits(real'(v));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_in_valid"},   64'(bus.in_valid),   64'd0);
        chk({tag, "_frame_done"}, 64'(bus.frame_done), 64'd0);
        chk({tag, "_fi_re"},      bus.fi_re,           64'd0);
        chk({tag, "_fi_im"},      bus.fi_im,           64'd0);
    endtask

    task automatic mk(input int base, output frame_t f);
        for (int i = 0; i < 8; i++) f[i] = base + i;
    endtask

    // Offers v[0..n-1]; returns at the falling edge where the last one is presented
    task automatic send_frame(input frame_t v, input int n, input bit gapped, input bit chk_first);
        int i;
        int cyc;
        bit tog;
        i = 0; cyc = 0; tog = 1'b0;
        while (i < n) begin
            @(negedge clk);
            if (cyc > 200) begin
                chk("send_timeout", 64'(i), 64'(n));
                return;
            end
            cyc++;
            if (chk_first && cyc == 1) chk("b2b_first_ready", 64'(bus.coef_ready), 64'd1);
            tog = gapped ? ~tog : 1'b1;
            bus.coef_valid = tog;
            bus.coef_data  = enc(v[i]);
            if (tog && bus.coef_ready) i++;
        end
        chk("pre_burst_in_valid", 64'(bus.in_valid), 64'd0);
    endtask

    // Checks beats 0..last_beat of a burst carrying frame v
    task automatic burst(input frame_t v, input int last_beat, input bit hold, input int hold_v);
        for (int b = 0; b <= last_beat; b++) begin
            @(negedge clk);
            if (b == 0) begin
                bus.coef_valid = hold;
                bus.coef_data  = enc(hold_v);
            end
            chk($sformatf("beat%0d_in_valid", b),   64'(bus.in_valid),   64'd1);
            chk($sformatf("beat%0d_fi_re", b),      bus.fi_re,           dbl(v[b]));
            chk($sformatf("beat%0d_fi_im", b),      bus.fi_im,           dbl(v[b + 4]));
            chk($sformatf("beat%0d_frame_done", b), 64'(bus.frame_done), 64'(b == 3));
            chk($sformatf("beat%0d_coef_ready", b), 64'(bus.coef_ready), 64'd0);
        end
    endtask

    task automatic post(input string tag);
        @(negedge clk);
        bus.coef_valid = 1'b0;
        chk_idle(tag);
        chk({tag, "_coef_ready"}, 64'(bus.coef_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t fa, fg, fc, fa2, fb, fp, fn, fd, fr, fs;
`ifdef INT2FP_EN
        frame_t fi;
`endif
        rst            = 1'b1;
        bus.coef_valid = 1'b0;
        bus.coef_data  = '0;
        bus.abort      = 1'b0;

        // reset held for 3 cycles
        repeat (3) @(negedge clk);
        chk_idle("rst");
        chk("rst_coef_ready", 64'(bus.coef_ready), 64'd0);
        rst = 1'b0;
        chk("rel_coef_ready_same", 64'(bus.coef_ready), 64'd0);
        @(negedge clk);
        chk("rel_coef_ready_next", 64'(bus.coef_ready), 64'd1);
        chk("rel_in_valid", 64'(bus.in_valid), 64'd0);

        // contiguous frame f[i]=i
        mk(0, fa);
        send_frame(fa, 8, 1'b0, 1'b0);
        burst(fa, 3, 1'b0, 0);
        post("contig_post");

        // gapped upstream, coef_valid held high through EMIT, then an intact next frame
        mk(10, fg);
        send_frame(fg, 8, 1'b1, 1'b0);
        burst(fg, 3, 1'b1, 99);
        post("gap_post");
        mk(50, fc);
        send_frame(fc, 8, 1'b0, 1'b0);
        burst(fc, 3, 1'b0, 0);
        post("after_gap_post");

        // back-to-back: B[0] offered throughout A's burst
        mk(20, fa2);
        mk(60, fb);
        send_frame(fa2, 8, 1'b0, 1'b0);
        burst(fa2, 3, 1'b1, fb[0]);
        send_frame(fb, 8, 1'b0, 1'b1);
        burst(fb, 3, 1'b0, 0);
        post("b2b_post");

        // abort after 5 accepts, with a coefficient offered in the abort cycle
        mk(30, fp);
        send_frame(fp, 5, 1'b0, 1'b0);
        @(negedge clk);
        bus.abort      = 1'b1;
        bus.coef_valid = 1'b1;
        bus.coef_data  = enc(77);
        @(negedge clk);
        bus.abort      = 1'b0;
        bus.coef_valid = 1'b0;
        chk("abort_load_coef_ready", 64'(bus.coef_ready), 64'd1);
        chk_idle("abort_load");
        mk(40, fn);
        send_frame(fn, 8, 1'b0, 1'b0);
        burst(fn, 3, 1'b0, 0);
        post("abort_load_post");

        // abort during beat 2 of EMIT
        mk(70, fd);
        send_frame(fd, 8, 1'b0, 1'b0);
        burst(fd, 2, 1'b0, 0);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk_idle("abort_emit");
        chk("abort_emit_coef_ready", 64'(bus.coef_ready), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("abort_emit_done_%0d", k), 64'(bus.frame_done), 64'd0);
            chk($sformatf("abort_emit_valid_%0d", k), 64'(bus.in_valid), 64'd0);
        end

        // asynchronous reset in the middle of a burst
        mk(80, fr);
        send_frame(fr, 8, 1'b0, 1'b0);
        @(negedge clk);
        bus.coef_valid = 1'b0;
        chk("arst_pre_in_valid", 64'(bus.in_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk_idle("arst");
        chk("arst_coef_ready", 64'(bus.coef_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_rel_coef_ready", 64'(bus.coef_ready), 64'd1);
        mk(90, fs);
        send_frame(fs, 8, 1'b0, 1'b0);
        burst(fs, 3, 1'b0, 0);
        post("arst_post");

`ifdef INT2FP_EN
        // integer conversion vector with hand-computed doubles
        fi[0] = 0;      fi[1] = 1;     fi[2] = -1; fi[3] = 2;
        fi[4] = -32768; fi[5] = 32767; fi[6] = 3;  fi[7] = -3;
        send_frame(fi, 8, 1'b0, 1'b0);
        @(negedge clk);
        bus.coef_valid = 1'b0;
        chk("i2f_b0_re", bus.fi_re, 64'h0000000000000000);
        chk("i2f_b0_im", bus.fi_im, 64'hC0E0000000000000);
        @(negedge clk);
        chk("i2f_b1_re", bus.fi_re, 64'h3FF0000000000000);
        chk("i2f_b1_im", bus.fi_im, 64'h40DFFFC000000000);
        @(negedge clk);
        chk("i2f_b2_re", bus.fi_re, 64'hBFF0000000000000);
        chk("i2f_b2_im", bus.fi_im, 64'h4008000000000000);
        @(negedge clk);
        chk("i2f_b3_re", bus.fi_re, 64'h4000000000000000);
        chk("i2f_b3_im", bus.fi_im, 64'hC008000000000000);
        chk("i2f_b3_done", 64'(bus.frame_done), 64'd1);
        post("i2f_post");
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
